// File: rtl/mem_access_unit.sv
// Load/store sequencer for the data memory. Requests that cross a word boundary become two word-aligned accesses.
// Data is big-endian. Define MISALIGN_TRAP_EN to reject word-crossing requests with rsp_err instead of splitting them.

module mem_access_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_mode,
  input  logic [WIDTH-1:0]      req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic                  we_q, err_q;
  logic [2:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q, base_addr;
  logic [WIDTH-1:0]      wdata_q, word0_q, rdata_q;

  logic                  accept, req_illegal, cur_split, cur_signed, unused_addr;
  logic [2:0]            cur_size;
  logic [1:0]            off;
  logic [3:0]            mask_left;
  logic [7:0]            wide_mask;
  logic [WIDTH-1:0]      data_left, word0, word1, load_top, load_ext;
  logic [2*WIDTH-1:0]    wide_wdata;

  // Access size in bytes; zero marks an illegal mode.
  function automatic logic [2:0] size_of(input logic [2:0] mode);
    case (mode)
      3'b001:         return 3'd4;
      3'b010, 3'b100: return 3'd2;
      3'b011, 3'b101: return 3'd1;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [2:0] mode, input logic [1:0] offset);
    return (size_of(mode) == 3'd4 && offset != 2'b00) || (size_of(mode) == 3'd2 && offset == 2'b11);
  endfunction

  assign accept      = req_valid && (state == IDLE);
  assign req_illegal = (size_of(req_mode) == 3'd0);
  assign unused_addr = ^req_addr[WIDTH-1:ADDR_WIDTH];
  assign cur_size    = size_of(mode_q);
  assign off         = addr_q[1:0];
  assign cur_split   = crosses_word(mode_q, off);
  assign cur_signed  = (mode_q == 3'b010) || (mode_q == 3'b011);
  assign base_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    rsp_err    = (state == RESP) && err_q;
    rsp_rdata  = rdata_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_illegal) state_next = RESP;
`ifdef MISALIGN_TRAP_EN
          else if (crosses_word(req_mode, req_addr[1:0])) state_next = RESP;
`endif
          else state_next = ISSUE0;
        end
      end
      ISSUE0: begin
        state_next = cur_split ? ISSUE1 : WAIT;
        mem_en     = 1'b1;
        mem_we     = we_q;
        mem_addr   = base_addr;
        mem_be     = wide_mask[7:4];
        mem_wdata  = we_q ? wide_wdata[2*WIDTH-1:WIDTH] : '0;
      end
      ISSUE1: begin
        state_next = WAIT;
        mem_en     = 1'b1;
        mem_we     = we_q;
        mem_addr   = base_addr + ADDR_WIDTH'(4);
        mem_be     = wide_mask[3:0];
        mem_wdata  = we_q ? wide_wdata[WIDTH-1:0] : '0;
      end
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lanes are handled as a two-word window: data is left-aligned, then shifted right by the byte offset.
  always_comb begin
    data_left = '0;
    mask_left = 4'b0000;
    case (cur_size)
      3'd4:    begin data_left = wdata_q;                  mask_left = 4'b1111; end
      3'd2:    begin data_left = {wdata_q[15:0], 16'h0000}; mask_left = 4'b1100; end
      default: begin data_left = {wdata_q[7:0], 24'h000000}; mask_left = 4'b1000; end
    endcase
    wide_wdata = {data_left, {WIDTH{1'b0}}} >> {off, 3'b000};
    wide_mask  = {mask_left, 4'b0000} >> off;

    word0    = cur_split ? word0_q : mem_rdata;
    word1    = cur_split ? mem_rdata : '0;
    load_top = (word0 << {off, 3'b000}) | (word1 >> (6'd32 - {1'b0, off, 3'b000}));
    case (cur_size)
      3'd4:    load_ext = load_top;
      3'd2:    load_ext = {{16{cur_signed & load_top[31]}}, load_top[31:16]};
      default: load_ext = {{24{cur_signed & load_top[31]}}, load_top[31:24]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        mode_q  <= req_mode;
        addr_q  <= req_addr[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
        err_q   <= req_illegal || crosses_word(req_mode, req_addr[1:0]);
`else
        err_q   <= req_illegal;
`endif
      end
      if (state == ISSUE1) word0_q <= mem_rdata;
      if (state == WAIT)   rdata_q <= we_q ? '0 : load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural big-endian data memory.
// The expected values follow MISALIGN_TRAP_EN when the bench is built with that macro defined.

module tb_mem_access_unit;

  localparam int AW = 17;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_mode;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [31:0]   rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct packed {
    int          cyc;
    logic [AW-1:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  acc_t exp_acc[$], obs_acc[$];
  rsp_t exp_rsp[$], obs_rsp[$];

  logic [31:0] mem [0:1023];
  wire unused_bits = ^{mem_addr[AW-1:12], mem_addr[1:0]};

  mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    return (old & ~lane_mask(be)) | (wd & lane_mask(be));
  endfunction

  // Synchronous memory: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_wdata, mem_be);
      else        mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  // Observation side of the scoreboard; only enabled lanes of store data are recorded.
  always @(negedge clk) begin
    if (mem_en) obs_acc.push_back('{cyc, mem_addr, mem_we, mem_be, mem_wdata & lane_mask(mem_be) & {32{mem_we}}});
    if (rsp_valid) obs_rsp.push_back('{cyc, rsp_rdata, rsp_err});
  end

  task automatic exp_a(input int c, input logic [AW-1:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    exp_acc.push_back('{c, a, we, be, wd});
  endtask

  task automatic exp_r(input int c, input logic [31:0] rd, input logic err);
    exp_rsp.push_back('{c, rd, err});
  endtask

  task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic aligned_req(input logic we, input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] lane_wd, input logic [31:0] rdata);
    int t;
    issue(we, mode, addr, wdata, t);
    exp_a(t + 1, {addr[AW-1:2], 2'b00}, we, be, lane_wd);
    exp_r(t + 3, rdata, 1'b0);
  endtask

  task automatic split_req(input logic we, input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [AW-1:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                           input logic [AW-1:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                           input logic [31:0] rdata);
    int t;
    issue(we, mode, addr, wdata, t);
    if (TRAP) begin
      exp_r(t + 1, 32'h0, 1'b1);
    end else begin
      exp_a(t + 1, a0, we, be0, wd0);
      exp_a(t + 2, a1, we, be1, wd1);
      exp_r(t + 4, rdata, 1'b0);
    end
  endtask

  task automatic illegal_req(input logic we, input logic [2:0] mode, input logic [31:0] addr);
    int t;
    issue(we, mode, addr, 32'h5555_5555, t);
    exp_r(t + 1, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_err, mem_en, mem_we, mem_be} !== 10'b10_0000_0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready=%b busy=%b rv=%b err=%b en=%b we=%b be=%b, required ready=1 others 0",
               req_ready, busy, rsp_valid, rsp_err, mem_en, mem_we, mem_be);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h required 0", rsp_rdata); end
    checks++;
    if (mem_addr !== 17'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: ready=%b busy=%b required 1/0", req_ready, busy);
    end
    rst = 1'b0;
    obs_acc.delete();
    obs_rsp.delete();
  endtask

  task automatic test_store_load();
    acc_t ea, oa;
    rsp_t er, orr;
    aligned_req(1'b1, 3'b001, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    aligned_req(1'b0, 3'b001, 32'h100, 32'h0, 4'b1111, 32'h0, 32'hDEADBEEF);
    aligned_req(1'b1, 3'b001, 32'h100, 32'h12F45678, 4'b1111, 32'h12F45678, 32'h0);
    aligned_req(1'b0, 3'b011, 32'h101, 32'h0, 4'b0100, 32'h0, 32'hFFFFFFF4);
    aligned_req(1'b0, 3'b101, 32'h101, 32'h0, 4'b0100, 32'h0, 32'h000000F4);
    aligned_req(1'b0, 3'b010, 32'h102, 32'h0, 4'b0011, 32'h0, 32'h00005678);
    aligned_req(1'b0, 3'b010, 32'h101, 32'h0, 4'b0110, 32'h0, 32'hFFFFF456);
    aligned_req(1'b0, 3'b100, 32'h101, 32'h0, 4'b0110, 32'h0, 32'h0000F456);
    aligned_req(1'b0, 3'b011, 32'h103, 32'h0, 4'b0001, 32'h0, 32'h00000078);
    aligned_req(1'b1, 3'b011, 32'h102, 32'h000000A5, 4'b0010, 32'h0000A500, 32'h0);
    aligned_req(1'b1, 3'b100, 32'h100, 32'h00009999, 4'b1100, 32'h99990000, 32'h0);
    aligned_req(1'b0, 3'b001, 32'h100, 32'h0, 4'b1111, 32'h0, 32'h9999A578);
    repeat (6) @(negedge clk);
    while (exp_acc.size() > 0) begin
      ea = exp_acc.pop_front();
      checks++;
      if (obs_acc.size() == 0) begin
        errors++;
        $display("[TB] FAIL store_load_access missing: required cyc=%0d addr=%h be=%b", ea.cyc, ea.addr, ea.be);
      end else begin
        oa = obs_acc.pop_front();
        if (oa !== ea) begin
          errors++;
          $display("[TB] FAIL store_load_access: got cyc=%0d addr=%h we=%b be=%b wd=%h, required cyc=%0d addr=%h we=%b be=%b wd=%h",
                   oa.cyc, oa.addr, oa.we, oa.be, oa.wdata, ea.cyc, ea.addr, ea.we, ea.be, ea.wdata);
        end
      end
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front();
      checks++;
      if (obs_rsp.size() == 0) begin
        errors++;
        $display("[TB] FAIL store_load_rsp missing: required cyc=%0d rdata=%h", er.cyc, er.rdata);
      end else begin
        orr = obs_rsp.pop_front();
        if (orr !== er) begin
          errors++;
          $display("[TB] FAIL store_load_rsp: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                   orr.cyc, orr.rdata, orr.err, er.cyc, er.rdata, er.err);
        end
      end
    end
    checks++;
    if (obs_acc.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("[TB] FAIL store_load_extra: %0d accesses %0d responses left, required 0", obs_acc.size(), obs_rsp.size());
    end
    obs_acc.delete();
    obs_rsp.delete();
  endtask

  task automatic test_split();
    acc_t ea, oa;
    rsp_t er, orr;
    aligned_req(1'b1, 3'b001, 32'h100, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD, 32'h0);
    aligned_req(1'b1, 3'b001, 32'h104, 32'h11223344, 4'b1111, 32'h11223344, 32'h0);
    aligned_req(1'b0, 3'b001, 32'hFFFE0104, 32'h0, 4'b1111, 32'h0, 32'h11223344);
    split_req(1'b0, 3'b001, 32'h102, 32'h0, 17'h100, 4'b0011, 32'h0, 17'h104, 4'b1100, 32'h0, 32'hCCDD1122);
    split_req(1'b0, 3'b010, 32'h103, 32'h0, 17'h100, 4'b0001, 32'h0, 17'h104, 4'b1000, 32'h0, 32'hFFFFDD11);
    split_req(1'b0, 3'b001, 32'h101, 32'h0, 17'h100, 4'b0111, 32'h0, 17'h104, 4'b1000, 32'h0, 32'hBBCCDD11);
    split_req(1'b1, 3'b010, 32'h103, 32'h0000ABCD, 17'h100, 4'b0001, 32'h000000AB, 17'h104, 4'b1000, 32'hCD000000, 32'h0);
    aligned_req(1'b0, 3'b001, 32'h100, 32'h0, 4'b1111, 32'h0, TRAP ? 32'hAABBCCDD : 32'hAABBCCAB);
    aligned_req(1'b0, 3'b001, 32'h104, 32'h0, 4'b1111, 32'h0, TRAP ? 32'h11223344 : 32'hCD223344);
    aligned_req(1'b1, 3'b001, 32'h1FFFC, 32'h01020304, 4'b1111, 32'h01020304, 32'h0);
    aligned_req(1'b1, 3'b001, 32'h0, 32'h05060708, 4'b1111, 32'h05060708, 32'h0);
    split_req(1'b0, 3'b001, 32'h1FFFE, 32'h0, 17'h1FFFC, 4'b0011, 32'h0, 17'h00000, 4'b1100, 32'h0, 32'h03040506);
    repeat (6) @(negedge clk);
    while (exp_acc.size() > 0) begin
      ea = exp_acc.pop_front();
      checks++;
      if (obs_acc.size() == 0) begin
        errors++;
        $display("[TB] FAIL split_access missing: required cyc=%0d addr=%h be=%b", ea.cyc, ea.addr, ea.be);
      end else begin
        oa = obs_acc.pop_front();
        if (oa !== ea) begin
          errors++;
          $display("[TB] FAIL split_access: got cyc=%0d addr=%h we=%b be=%b wd=%h, required cyc=%0d addr=%h we=%b be=%b wd=%h",
                   oa.cyc, oa.addr, oa.we, oa.be, oa.wdata, ea.cyc, ea.addr, ea.we, ea.be, ea.wdata);
        end
      end
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front();
      checks++;
      if (obs_rsp.size() == 0) begin
        errors++;
        $display("[TB] FAIL split_rsp missing: required cyc=%0d rdata=%h", er.cyc, er.rdata);
      end else begin
        orr = obs_rsp.pop_front();
        if (orr !== er) begin
          errors++;
          $display("[TB] FAIL split_rsp: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                   orr.cyc, orr.rdata, orr.err, er.cyc, er.rdata, er.err);
        end
      end
    end
    checks++;
    if (obs_acc.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("[TB] FAIL split_extra: %0d accesses %0d responses left, required 0", obs_acc.size(), obs_rsp.size());
    end
    obs_acc.delete();
    obs_rsp.delete();
  endtask

  task automatic test_illegal();
    rsp_t er, orr;
    illegal_req(1'b0, 3'b111, 32'h100);
    illegal_req(1'b1, 3'b000, 32'h100);
    illegal_req(1'b0, 3'b110, 32'h104);
    if (TRAP) split_req(1'b0, 3'b001, 32'h101, 32'h0, 17'h100, 4'b0111, 32'h0, 17'h104, 4'b1000, 32'h0, 32'h0);
    aligned_req(1'b0, 3'b001, 32'h100, 32'h0, 4'b1111, 32'h0, TRAP ? 32'hAABBCCDD : 32'hAABBCCAB);
    repeat (6) @(negedge clk);
    checks++;
    if (obs_acc.size() != 1) begin
      errors++;
      $display("[TB] FAIL illegal_access_count: got %0d accesses, required 1", obs_acc.size());
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front();
      checks++;
      if (obs_rsp.size() == 0) begin
        errors++;
        $display("[TB] FAIL illegal_rsp missing: required cyc=%0d err=%b", er.cyc, er.err);
      end else begin
        orr = obs_rsp.pop_front();
        if (orr !== er) begin
          errors++;
          $display("[TB] FAIL illegal_rsp: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                   orr.cyc, orr.rdata, orr.err, er.cyc, er.rdata, er.err);
        end
      end
    end
    exp_acc.delete();
    obs_acc.delete();
    obs_rsp.delete();
  endtask

  task automatic test_reset_midop();
    acc_t ea, oa;
    rsp_t er, orr;
    int t;
    issue(1'b0, 3'b001, 32'h102, 32'h0, t);
    if (TRAP) exp_r(t + 1, 32'h0, 1'b1);
    else      exp_a(t + 1, 17'h100, 1'b0, 4'b0011, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, mem_en, mem_we, mem_be} !== 9'b1_0000_0000 || mem_addr !== 17'h0) begin
      errors++;
      $display("[TB] FAIL midop_reset: ready=%b busy=%b rv=%b en=%b we=%b be=%b addr=%h, required ready=1 others 0",
               req_ready, busy, rsp_valid, mem_en, mem_we, mem_be, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    aligned_req(1'b0, 3'b001, 32'h104, 32'h0, 4'b1111, 32'h0, TRAP ? 32'h11223344 : 32'hCD223344);
    repeat (6) @(negedge clk);
    while (exp_acc.size() > 0) begin
      ea = exp_acc.pop_front();
      checks++;
      if (obs_acc.size() == 0) begin
        errors++;
        $display("[TB] FAIL midop_access missing: required cyc=%0d addr=%h be=%b", ea.cyc, ea.addr, ea.be);
      end else begin
        oa = obs_acc.pop_front();
        if (oa !== ea) begin
          errors++;
          $display("[TB] FAIL midop_access: got cyc=%0d addr=%h we=%b be=%b, required cyc=%0d addr=%h we=%b be=%b",
                   oa.cyc, oa.addr, oa.we, oa.be, ea.cyc, ea.addr, ea.we, ea.be);
        end
      end
    end
    while (exp_rsp.size() > 0) begin
      er = exp_rsp.pop_front();
      checks++;
      if (obs_rsp.size() == 0) begin
        errors++;
        $display("[TB] FAIL midop_rsp missing: required cyc=%0d rdata=%h", er.cyc, er.rdata);
      end else begin
        orr = obs_rsp.pop_front();
        if (orr !== er) begin
          errors++;
          $display("[TB] FAIL midop_rsp: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                   orr.cyc, orr.rdata, orr.err, er.cyc, er.rdata, er.err);
        end
      end
    end
    checks++;
    if (obs_acc.size() != 0 || obs_rsp.size() != 0) begin
      errors++;
      $display("[TB] FAIL midop_extra: %0d accesses %0d responses left, required 0", obs_acc.size(), obs_rsp.size());
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_mode  = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    test_reset();
    test_store_load();
    test_split();
    test_illegal();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the execute-stage address/data and the byte-addressed data memory. It accepts one load or store request at a time and converts it into one or two word-aligned memory accesses with byte enables. Unaligned accesses that cross a word boundary are split into two accesses, and load data is extracted and extended before it is returned. The core stalls on `busy` while a request is in flight.

Parameters:
WIDTH, 32, data/address word width (fixed at 32; other values unsupported)
ADDR_WIDTH, 17, memory byte-address width; upper req_addr bits ignored

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request
req_we  input  1  1=store, 0=load
req_mode  input  3  001 word, 010 half, 011 byte, 100 half-unsigned, 101 byte-unsigned
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, right-aligned
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  WIDTH  extended load data (0 for stores/errors)
rsp_err  output  1  qualifies rsp_valid: illegal mode (or trapped misalign)
busy  output  1  request in flight (stall)
mem_en  output  1  memory access this cycle
mem_we  output  1  write access
mem_addr  output  ADDR_WIDTH  word-aligned byte address, [1:0]=00
mem_be  output  4  byte enables, bit 3 = bits[31:24]
mem_wdata  output  WIDTH  lane-positioned write data
mem_rdata  input  WIDTH  read word, valid cycle after mem_en

Behaviour:
- Clock/reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Byte order is big-endian within a word: byte offset k maps to bits [31-8k:24-8k] and mem_be[3-k]. Multi-byte data is stored MSB at the lowest address.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP.
- req_ready = 1 only in IDLE. busy = !IDLE. A request is accepted when req_valid && req_ready; the unit latches we/mode/addr/wdata.
- Split condition: word with addr[1:0]≠00, or half with addr[1:0]=11. Bytes never split.
- IDLE→ISSUE0 on accept.
- Illegal mode (000, 110, 111): IDLE→RESP with no memory access, rsp_err=1.
- ISSUE0: mem_en=1, mem_addr={addr[ADDR_WIDTH-1:2],00}, mem_be/mem_wdata for the first-word bytes. Next state is ISSUE1 if split, otherwise WAIT.
- ISSUE1: captures mem_rdata into the low-word buffer. Issues the second access at first address + 4, wrapping modulo 2^ADDR_WIDTH, with enables for the remaining bytes from offset 0. Next state is WAIT.
- WAIT: captures mem_rdata, assembles bytes in address order, and applies extension. Signed modes sign-extend from the MSB byte; unsigned modes zero-extend. Registers rsp_rdata. Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Stores follow the same path. mem_we=1 on every issued access, and rsp_rdata=0.
- Modes 100/101 used with stores act as half/byte stores.
- Latency from accept cycle T:
  - aligned: rsp_valid at T+3
  - split: rsp_valid at T+4
  - illegal: rsp_valid at T+1
- mem_en=0 and mem_be=0 in IDLE, WAIT and RESP.
- Reset values: state IDLE, all outputs 0 except req_ready=1.
- Reset mid-operation aborts immediately. A first split-store word already written is not rolled back.
- A req_valid during busy is ignored; the requester holds it until req_ready.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: split-condition requests issue no memory access. They go IDLE→RESP with rsp_err=1, rsp_rdata=0, rsp_valid at T+1.
- Undefined: splitting as above; misaligned requests never set rsp_err.

Test Plan:
1. Store word 0x100, wdata 0xDEADBEEF → single access at T+1: mem_addr 0x100, be 1111, wdata 0xDEADBEEF; rsp_valid at T+3, rsp_err 0.
2. mem[0x100]=0x12F45678 → load byte (011) at 0x101 returns 0xFFFFFFF4; load byte-unsigned (101) at 0x101 returns 0x000000F4; load half (010) at 0x102 returns 0x00005678.
3. mem[0x100]=0xAABBCCDD, mem[0x104]=0x11223344 → load word at 0x102 issues 0x100 then 0x104 on consecutive cycles; rsp_rdata 0xCCDD1122 at T+4.
4. Store half at 0x103, wdata 0x0000ABCD → access 0x100 be 0001 with wdata[7:0]=0xAB, then 0x104 be 1000 with wdata[31:24]=0xCD; rsp_valid T+4.
5. Request with mode 111 → no mem_en, rsp_valid and rsp_err at T+1. With MISALIGN_TRAP_EN, a word load at 0x101 gives the same response.
6. Assert rst during ISSUE1 of a split load → outputs 0 and req_ready 1 immediately, no rsp_valid; a new aligned load after release completes at T+3.
